// File: rtl/clic_gateway_pkg.sv
// clic_gateway_pkg: trigger-mode encoding and the edge-mode pending update
// shared by the per-source gateway cells.
package clic_gateway_pkg;

   // clicint attr_trig[0] encoding
   typedef enum logic {
      TRIG_LEVEL = 1'b0,
      TRIG_EDGE  = 1'b1
   } trig_e;

   // Edge-mode pending update. A fresh edge outranks a software write,
   // which outranks a claim, so an edge arriving alongside a clear is kept.
   function automatic logic edge_pend_next(
      input logic pend_q,
      input logic rise,
      input logic sw_we,
      input logic sw_wdata,
      input logic claim_hit
   );
      logic v;
      v = pend_q;
      if (rise) begin
         v = 1'b1;
      end else if (sw_we) begin
         v = sw_wdata;
      end else if (claim_hit) begin
         v = 1'b0;
      end
      return v;
   endfunction

endpackage

// File: rtl/clic_gateway_cell.sv
// clic_gateway_cell: one interrupt source's synchronizer, rising-edge
// detector and pending flop.
//   clk_i, rst_ni  : clock, async active-low reset
//   src_i          : raw interrupt line (may be asynchronous)
//   le_i           : 0 = level, 1 = edge trigger
//   sw_we_i        : software write strobe on this source's ip bit
//   sw_wdata_i     : software write data
//   claim_hit_i    : core has claimed this source
//   pend_o         : registered pending bit
module clic_gateway_cell
   import clic_gateway_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic src_i,
   input  logic le_i,
   input  logic sw_we_i,
   input  logic sw_wdata_i,
   input  logic claim_hit_i,
   output logic pend_o
);

   logic w_s;
   logic w_rise;
   logic w_pend_d;
   logic r_prev;
   logic r_pend;

   // Synchronizer chain, or a straight wire for already-synchronous sources
   generate
      if (SYNC_STAGES == 0) begin : g_bypass
         assign w_s = src_i;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] r_sync;

         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               r_sync <= '0;
            end else begin
               r_sync[0] <= src_i;
               for (int k = 1; k < int'(SYNC_STAGES); k++) begin
                  r_sync[k] <= r_sync[k-1];
               end
            end
         end

         assign w_s = r_sync[SYNC_STAGES-1];
      end
   endgenerate

   // prev tracks s in both modes so switching mode never sees stale history
   assign w_rise = w_s & ~r_prev;

   // Next pending value: level mode mirrors s, edge mode latches
   always_comb begin
      w_pend_d = r_pend;
      if (trig_e'(le_i) == TRIG_LEVEL) begin
         w_pend_d = w_s;
      end else begin
         w_pend_d = edge_pend_next(r_pend, w_rise, sw_we_i, sw_wdata_i,
                                   claim_hit_i);
      end
   end

   // History and pending registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_prev <= 1'b0;
         r_pend <= 1'b0;
      end else begin
         r_prev <= w_s;
         r_pend <= w_pend_d;
      end
   end

   assign pend_o = r_pend;

endmodule

// File: rtl/clic_gateway.sv
// clic_gateway: per-source CLIC interrupt gateway. Synchronizes raw lines,
// applies level/edge triggering and drives the pending vector consumed by
// the clicint register adapter.
//   clk_i, rst_ni  : clock, async active-low reset
//   intr_src_i     : raw interrupt lines
//   le_i           : per-source trigger select (0 level, 1 edge)
//   sw_ip_we_i     : per-source software write strobe on ip
//   sw_ip_wdata_i  : per-source software write data
//   claim_valid_i  : one-cycle claim pulse
//   claim_id_i     : claimed source id
//   ip_o           : registered pending vector
module clic_gateway
   import clic_gateway_pkg::*;
#(
   parameter int unsigned N_SOURCE    = 32,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned ID_W        = (N_SOURCE > 1) ? $clog2(N_SOURCE) : 1
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [N_SOURCE-1:0] intr_src_i,
   input  logic [N_SOURCE-1:0] le_i,
   input  logic [N_SOURCE-1:0] sw_ip_we_i,
   input  logic [N_SOURCE-1:0] sw_ip_wdata_i,
   input  logic                claim_valid_i,
   input  logic [ID_W-1:0]     claim_id_i,
   output logic [N_SOURCE-1:0] ip_o
);

   logic [N_SOURCE-1:0] w_claim_hit;
   logic [N_SOURCE-1:0] w_pend;

   // One-hot claim decode; ids at or above N_SOURCE match no source
   always_comb begin
      w_claim_hit = '0;
      for (int unsigned i = 0; i < N_SOURCE; i++) begin
         w_claim_hit[i] = claim_valid_i && (claim_id_i == ID_W'(i));
      end
   end

   generate
      for (genvar g = 0; g < int'(N_SOURCE); g++) begin : g_cell
         clic_gateway_cell #(
            .SYNC_STAGES (SYNC_STAGES)
         ) u_cell (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .src_i       (intr_src_i[g]),
            .le_i        (le_i[g]),
            .sw_we_i     (sw_ip_we_i[g]),
            .sw_wdata_i  (sw_ip_wdata_i[g]),
            .claim_hit_i (w_claim_hit[g]),
            .pend_o      (w_pend[g])
         );
      end
   endgenerate

   assign ip_o = w_pend;

endmodule

// File: tb/tb_clic_gateway.sv
// tb_clic_gateway: directed + randomized bench with a cycle-level reference
// model and a scoreboard queue popped by an independent monitor.
module tb_clic_gateway;

   localparam int unsigned N    = 24;
   localparam int unsigned SYNC = 2;
   localparam int unsigned IDW  = 5;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   intr_src;
   logic [N-1:0]   le;
   logic [N-1:0]   sw_we;
   logic [N-1:0]   sw_wd;
   logic           cv;
   logic [IDW-1:0] cid;
   logic [N-1:0]   ip;

   always #5 clk = ~clk;

   clic_gateway #(
      .N_SOURCE    (N),
      .SYNC_STAGES (SYNC),
      .ID_W        (IDW)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .intr_src_i    (intr_src),
      .le_i          (le),
      .sw_ip_we_i    (sw_we),
      .sw_ip_wdata_i (sw_wd),
      .claim_valid_i (cv),
      .claim_id_i    (cid),
      .ip_o          (ip)
   );

   // Bench-side stimulus values; strobes auto-clear after each step
   logic [N-1:0]   b_src, b_le, b_we, b_wd;
   logic           b_cv;
   logic [IDW-1:0] b_cid;

   // Reference model state
   logic [N-1:0] src_hist[$];
   logic [N-1:0] m_prev, m_pend;
   logic [N-1:0] exp_q[$];
   int           checks = 0;
   int           errors = 0;
   int           cyc    = 0;

   function automatic void model_reset();
      src_hist.delete();
      m_prev = '0;
      m_pend = '0;
   endfunction

   // Expected pending after the coming clock edge
   function automatic void model_edge();
      logic [N-1:0] s;
      src_hist.push_back(b_src);
      // s seen at this edge is the source value driven SYNC edges earlier
      if (src_hist.size() > SYNC) s = src_hist[src_hist.size()-1-SYNC];
      else                         s = '0;
      for (int i = 0; i < int'(N); i++) begin
         if (!b_le[i]) begin
            m_pend[i] = s[i];
         end else if (s[i] && !m_prev[i]) begin
            m_pend[i] = 1'b1;
         end else if (b_we[i]) begin
            m_pend[i] = b_wd[i];
         end else if (b_cv && (int'(b_cid) == i)) begin
            m_pend[i] = 1'b0;
         end
      end
      m_prev = s;
      if (src_hist.size() > SYNC + 1) void'(src_hist.pop_front());
   endfunction

   // Called at a negedge: apply inputs for the next edge, push expectation
   task automatic step();
      intr_src = b_src;
      le       = b_le;
      sw_we    = b_we;
      sw_wd    = b_wd;
      cv       = b_cv;
      cid      = b_cid;
      model_edge();
      exp_q.push_back(m_pend);
      b_we = '0;
      b_cv = 1'b0;
      @(negedge clk);
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   // Async reset between edges, then release at a negedge
   task automatic async_reset(input int hold);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (ip !== '0) begin
         errors++;
         $display("FAIL async_reset_clear: ip_o=%h expected %h", ip, {N{1'b0}});
      end
      exp_q.delete();
      model_reset();
      intr_src = b_src;
      le       = b_le;
      sw_we    = '0;
      cv       = 1'b0;
      repeat (hold) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: ip_o is valid every cycle; compare against queued expectation
   initial begin
      logic [N-1:0] e;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (ip !== e) begin
               errors++;
               $display("FAIL ip_o cycle %0d: got %h expected %h", cyc, ip, e);
            end
         end
      end
   end

   initial begin
      b_src = '0; b_le = '0; b_we = '0; b_wd = '0; b_cv = 1'b0; b_cid = '0;
      intr_src = '0; le = '0; sw_we = '0; sw_wd = '0; cv = 1'b0; cid = '0;
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      checks++;
      if (ip !== '0) begin
         errors++;
         $display("FAIL reset_state: ip_o=%h expected %h", ip, {N{1'b0}});
      end
      rst_n = 1'b1;

      // Edge on source 3, hold high, claim later; no re-pend while high
      b_le[3] = 1'b1;
      steps(10);
      b_src[3] = 1'b1;
      steps(10);
      b_cv = 1'b1; b_cid = IDW'(3);
      steps(8);

      // Rise coincident with claim, then with a sw clear
      b_le[4] = 1'b1;
      b_src[4] = 1'b1;
      steps(2);
      b_cv = 1'b1; b_cid = IDW'(4);
      steps(4);
      b_src[4] = 1'b0;
      steps(4);
      b_src[4] = 1'b1;
      steps(2);
      b_we[4] = 1'b1; b_wd[4] = 1'b0;
      steps(4);

      // Level mode on source 5; claim and sw write ignored
      b_src[5] = 1'b1;
      steps(2);
      b_cv = 1'b1; b_cid = IDW'(5);
      step();
      b_we[5] = 1'b1; b_wd[5] = 1'b0;
      steps(2);
      b_src[5] = 1'b0;
      steps(5);

      // Software set/clear on idle source 7, then out-of-range claim
      b_le[7] = 1'b1;
      b_we[7] = 1'b1; b_wd[7] = 1'b1;
      step();
      b_we[7] = 1'b1; b_wd[7] = 1'b0;
      step();
      b_we[7] = 1'b1; b_wd[7] = 1'b1;
      step();
      b_cv = 1'b1; b_cid = IDW'(30);
      steps(2);

      // Level->edge switch with source 2 high, then claim
      b_src[2] = 1'b1;
      steps(4);
      b_le[2] = 1'b1;
      steps(3);
      b_cv = 1'b1; b_cid = IDW'(2);
      steps(4);

      // Async reset with several ip bits set, source 0 held high across it
      b_le[5] = 1'b0; b_src[5] = 1'b1;
      b_le[0] = 1'b1; b_src[0] = 1'b1;
      steps(4);
      async_reset(2);
      steps(6);

      // Randomized traffic
      for (int t = 0; t < 3000; t++) begin
         for (int i = 0; i < int'(N); i++) begin
            if ($urandom_range(0, 7) == 0) b_src[i] = ~b_src[i];
            if ($urandom_range(0, 63) == 0) b_le[i] = ~b_le[i];
            b_we[i] = ($urandom_range(0, 15) == 0);
            b_wd[i] = 1'($urandom_range(0, 1));
         end
         b_cv  = ($urandom_range(0, 2) == 0);
         b_cid = IDW'($urandom_range(0, 31));
         if ($urandom_range(0, 999) == 0) async_reset(1);
         step();
      end

      b_src = '0;
      steps(4);
      repeat (3) @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
